// File: rtl/pusch_pkg.sv
// Shared PUSCH transmit-chain definitions: NR numerology and the
// round-and-saturate helper used wherever a wide sample is narrowed.
package pusch_pkg;

    localparam int FFT_LEN       = 2048;
    localparam int CP_NORM       = 144;
    localparam int CP_LONG       = 160;
    localparam int SYMS_PER_SLOT = 14;
    localparam logic [SYMS_PER_SLOT-1:0] LONG_CP_MASK = 14'b00000010000001;

    typedef struct packed {
        logic signed [63:0] val;
        logic               sat;
    } round_sat_t;

    // Round half up by adding 2^(shift-1) before an arithmetic shift, then clamp
    // to a signed w_out-bit range. 64-bit intermediates cover any practical input.
    function automatic round_sat_t round_sat(
        input logic signed [63:0] x,
        input int                 shift,
        input int                 w_out
    );
        round_sat_t         res;
        logic signed [63:0] y;
        logic signed [63:0] hi;
        logic signed [63:0] lo;
        y  = (shift > 0) ? ((x + (64'sd1 <<< (shift - 1))) >>> shift) : x;
        hi = (64'sd1 <<< (w_out - 1)) - 64'sd1;
        lo = -(64'sd1 <<< (w_out - 1));
        res.sat = (y > hi) || (y < lo);
        if (y > hi) begin
            res.val = hi;
        end else if (y < lo) begin
            res.val = lo;
        end else begin
            res.val = y;
        end
        return res;
    endfunction

endpackage

// File: rtl/sync_fifo_fwft.sv
// Single-clock first-word-fall-through FIFO. The head word is visible on
// rd_data whenever the FIFO is non-empty; a write into a full FIFO is dropped.
module sync_fifo_fwft #(
    parameter int  WIDTH = 34,
    parameter int  DEPTH = 512,
    localparam int AW    = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             wr_en,
    input  logic [WIDTH-1:0] wr_data,
    output logic             wr_drop,
    input  logic             rd_en,
    output logic [WIDTH-1:0] rd_data,
    output logic             empty,
    output logic             full,
    output logic [AW:0]      fill
);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW:0]      wr_ptr_q, wr_ptr_d;
    logic [AW:0]      rd_ptr_q, rd_ptr_d;
    logic             do_wr, do_rd;

    // NOTE: every signal assigned in always_comb gets a default at the top of
    // the block, so no path can leave it unassigned and infer a latch.
    always_comb begin
        fill     = wr_ptr_q - rd_ptr_q;
        empty    = (fill == '0);
        full     = (fill == (AW+1)'(DEPTH));
        do_rd    = rd_en && !empty;
        // A read in the same cycle frees the slot, so a full FIFO still accepts.
        do_wr    = wr_en && (!full || do_rd);
        wr_drop  = wr_en && !do_wr;
        wr_ptr_d = wr_ptr_q + {{AW{1'b0}}, do_wr};
        rd_ptr_d = rd_ptr_q + {{AW{1'b0}}, do_rd};
        rd_data  = empty ? '0 : mem[rd_ptr_q[AW-1:0]];
    end

    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples the pre-edge value of its inputs, independent of block order.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
        end
    end

    // NOTE: the storage array is deliberately not reset; the pointers define
    // which entries are meaningful, and an unreset array maps onto RAM.
    always_ff @(posedge clk) begin
        if (do_wr) begin
            mem[wr_ptr_q[AW-1:0]] <= wr_data;
        end
    end

endmodule

// File: rtl/tx_sample_framer.sv
// Transmit output framer: rounds/saturates IFFT+CP samples, tags slot and
// symbol boundaries, and buffers them onto a valid/ready stream.
module tx_sample_framer #(
    parameter int WIDTH_IN      = 26,
    parameter int WIDTH_OUT     = 16,
    parameter int SHIFT         = 10,
    parameter int FFT_LEN       = pusch_pkg::FFT_LEN,
    parameter int CP_NORM       = pusch_pkg::CP_NORM,
    parameter int CP_LONG       = pusch_pkg::CP_LONG,
    parameter int SYMS_PER_SLOT = pusch_pkg::SYMS_PER_SLOT,
    parameter logic [SYMS_PER_SLOT-1:0] LONG_CP_MASK = pusch_pkg::LONG_CP_MASK,
    parameter int FIFO_DEPTH    = 512,
    localparam int FILL_W       = $clog2(FIFO_DEPTH) + 1
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [WIDTH_IN-1:0]  in_r,
    input  logic [WIDTH_IN-1:0]  in_i,
    input  logic                 in_valid,
    input  logic                 clr_flags,
    output logic [WIDTH_OUT-1:0] out_r,
    output logic [WIDTH_OUT-1:0] out_i,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic                 out_sos,
    output logic                 out_eos,
    output logic                 overflow,
    output logic                 sat_seen,
    output logic [FILL_W-1:0]    fill
);

    localparam int SAMP_W = $clog2(CP_LONG + FFT_LEN);
    localparam int SYM_W  = $clog2(SYMS_PER_SLOT);
    localparam int WORD_W = 2 * WIDTH_OUT + 2;

    logic [SAMP_W-1:0]    samp_cnt_q, samp_cnt_d;
    logic [SYM_W-1:0]     sym_cnt_q, sym_cnt_d;
    logic                 s1_valid_q, s1_valid_d;
    logic [WIDTH_OUT-1:0] s1_r_q, s1_r_d;
    logic [WIDTH_OUT-1:0] s1_i_q, s1_i_d;
    logic                 s1_sos_q, s1_sos_d;
    logic                 s1_eos_q, s1_eos_d;
    logic                 overflow_q, overflow_d;
    logic                 sat_seen_q, sat_seen_d;

    pusch_pkg::round_sat_t rs_r, rs_i;
    logic [SAMP_W-1:0]     last_samp;
    logic                  is_last;
    logic                  fifo_empty, fifo_full, fifo_drop;
    logic [WORD_W-1:0]     fifo_rd_data;

    always_comb begin
        rs_r = pusch_pkg::round_sat(64'(signed'(in_r)), SHIFT, WIDTH_OUT);
        rs_i = pusch_pkg::round_sat(64'(signed'(in_i)), SHIFT, WIDTH_OUT);

        last_samp = LONG_CP_MASK[sym_cnt_q] ? SAMP_W'(CP_LONG + FFT_LEN - 1)
                                            : SAMP_W'(CP_NORM + FFT_LEN - 1);
        is_last   = (samp_cnt_q == last_samp);

        // Position tracks every input sample, stored or dropped downstream.
        samp_cnt_d = samp_cnt_q;
        sym_cnt_d  = sym_cnt_q;
        if (in_valid) begin
            if (is_last) begin
                samp_cnt_d = '0;
                sym_cnt_d  = (sym_cnt_q == SYM_W'(SYMS_PER_SLOT - 1)) ? '0
                                                                       : sym_cnt_q + SYM_W'(1);
            end else begin
                samp_cnt_d = samp_cnt_q + SAMP_W'(1);
            end
        end

        s1_valid_d = in_valid;
        s1_r_d     = s1_r_q;
        s1_i_d     = s1_i_q;
        s1_sos_d   = s1_sos_q;
        s1_eos_d   = s1_eos_q;
        if (in_valid) begin
            s1_r_d   = rs_r.val[WIDTH_OUT-1:0];
            s1_i_d   = rs_i.val[WIDTH_OUT-1:0];
            s1_sos_d = (samp_cnt_q == '0) && (sym_cnt_q == '0);
            s1_eos_d = is_last;
        end

        // Clear first, then set, so a coincident new event keeps the flag high.
        overflow_d = overflow_q;
        sat_seen_d = sat_seen_q;
        if (clr_flags) begin
            overflow_d = 1'b0;
            sat_seen_d = 1'b0;
        end
        if (fifo_drop) begin
            overflow_d = 1'b1;
        end
        if (in_valid && (rs_r.sat || rs_i.sat)) begin
            sat_seen_d = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            samp_cnt_q <= '0;
            sym_cnt_q  <= '0;
            s1_valid_q <= 1'b0;
            s1_r_q     <= '0;
            s1_i_q     <= '0;
            s1_sos_q   <= 1'b0;
            s1_eos_q   <= 1'b0;
            overflow_q <= 1'b0;
            sat_seen_q <= 1'b0;
        end else begin
            samp_cnt_q <= samp_cnt_d;
            sym_cnt_q  <= sym_cnt_d;
            s1_valid_q <= s1_valid_d;
            s1_r_q     <= s1_r_d;
            s1_i_q     <= s1_i_d;
            s1_sos_q   <= s1_sos_d;
            s1_eos_q   <= s1_eos_d;
            overflow_q <= overflow_d;
            sat_seen_q <= sat_seen_d;
        end
    end

    sync_fifo_fwft #(
        .WIDTH (WORD_W),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk     (clk),
        .rst_n   (rst_n),
        .wr_en   (s1_valid_q),
        .wr_data ({s1_r_q, s1_i_q, s1_sos_q, s1_eos_q}),
        .wr_drop (fifo_drop),
        .rd_en   (out_ready),
        .rd_data (fifo_rd_data),
        .empty   (fifo_empty),
        .full    (fifo_full),
        .fill    (fill)
    );

    always_comb begin
        out_valid = !fifo_empty;
        {out_r, out_i, out_sos, out_eos} = fifo_rd_data;
        overflow  = overflow_q;
        sat_seen  = sat_seen_q;
    end

endmodule

// File: tb/tb_tx_sample_framer.sv
// Self-checking bench for tx_sample_framer: a scoreboard of expected output
// beats is filled as samples are driven and drained by a negedge monitor.
module tb_tx_sample_framer;

    localparam int SLOT_LEN = 30720;
    localparam int DEPTH    = 512;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [25:0] in_r = '0;
    logic [25:0] in_i = '0;
    logic        in_valid = 1'b0;
    logic        clr_flags = 1'b0;
    logic        out_ready = 1'b0;
    logic [15:0] out_r, out_i;
    logic        out_valid, out_sos, out_eos, overflow, sat_seen;
    logic [9:0]  fill;

    tx_sample_framer dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_r      (in_r),
        .in_i      (in_i),
        .in_valid  (in_valid),
        .clr_flags (clr_flags),
        .out_r     (out_r),
        .out_i     (out_i),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_sos   (out_sos),
        .out_eos   (out_eos),
        .overflow  (overflow),
        .sat_seen  (sat_seen),
        .fill      (fill)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [15:0] r;
        logic [15:0] i;
        logic        sos;
        logic        eos;
    } exp_t;

    exp_t sb[$];
    int   n_checks = 0;
    int   n_pass   = 0;
    int   m_pos    = 0;
    int   sym_end[14];
    int   beats = 0, eos_beats = 0, sos_beats = 0;
    logic first_sos = 1'b0;

    // Reference rounding by floor division, independent of shift arithmetic.
    function automatic int model_round(input longint x);
        longint n, q;
        n = x + 512;
        q = n / 1024;
        if ((n % 1024 != 0) && (n < 0)) q = q - 1;
        if (q > 32767) q = 32767;
        if (q < -32768) q = -32768;
        return int'(q);
    endfunction

    function automatic bit pos_is_eos(input int p);
        for (int s = 0; s < 14; s++) begin
            if (p == sym_end[s] - 1) return 1'b1;
        end
        return 1'b0;
    endfunction

    task automatic drive_sample(input logic [25:0] r, input logic [25:0] i, input bit stored);
        exp_t e;
        e.r   = 16'(model_round(longint'($signed(r))));
        e.i   = 16'(model_round(longint'($signed(i))));
        e.sos = (m_pos == 0);
        e.eos = pos_is_eos(m_pos);
        if (stored) sb.push_back(e);
        m_pos    = (m_pos + 1) % SLOT_LEN;
        in_r     = r;
        in_i     = i;
        in_valid = 1'b1;
        @(posedge clk);
        #1;
    endtask

    always @(negedge clk) begin : monitor
        exp_t e;
        if (rst_n && out_valid && out_ready) begin
            n_checks++;
            if (sb.size() == 0) begin
                $display("FAIL unexpected_beat: got r=%0d i=%0d sos=%0b eos=%0b, required no beat",
                         $signed(out_r), $signed(out_i), out_sos, out_eos);
            end else begin
                e = sb.pop_front();
                if ({out_r, out_i, out_sos, out_eos} !== {e.r, e.i, e.sos, e.eos})
                    $display("FAIL beat_%0d: got r=%0d i=%0d sos=%0b eos=%0b, required r=%0d i=%0d sos=%0b eos=%0b",
                             beats, $signed(out_r), $signed(out_i), out_sos, out_eos,
                             $signed(e.r), $signed(e.i), e.sos, e.eos);
                else
                    n_pass++;
            end
            if (beats == 0) first_sos = out_sos;
            beats++;
            if (out_eos) eos_beats++;
            if (out_sos) sos_beats++;
        end
    end

    task automatic wait_drain(input int budget);
        int k = 0;
        while ((sb.size() != 0 || out_valid) && k < budget) begin
            @(posedge clk);
            #1;
            k++;
        end
        n_checks++;
        if (sb.size() == 0 && !out_valid) n_pass++;
        else $display("FAIL drain_timeout: got %0d beats outstanding, required 0", sb.size());
    endtask

    task automatic apply_reset();
        in_valid  = 1'b0;
        clr_flags = 1'b0;
        @(posedge clk);
        #2;
        rst_n = 1'b0;
        sb.delete();
        m_pos = 0;
        repeat (3) @(negedge clk);
        n_checks++;
        if ({out_valid, out_r, out_i, out_sos, out_eos, overflow, sat_seen, fill} !== '0)
            $display("FAIL reset_state: got valid=%0b r=%0h i=%0h sos=%0b eos=%0b ovf=%0b sat=%0b fill=%0d, required all 0",
                     out_valid, out_r, out_i, out_sos, out_eos, overflow, sat_seen, fill);
        else
            n_pass++;
        beats = 0; eos_beats = 0; sos_beats = 0; first_sos = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        apply_reset();
    endtask

    // One sample in with the sink stalled: check latency, head value, stability.
    task automatic round_case(input logic [25:0] r, input logic [25:0] i,
                              input logic [15:0] er, input logic [15:0] ei);
        out_ready = 1'b0;
        drive_sample(r, i, 1'b1);
        in_valid = 1'b0;
        @(negedge clk);
        n_checks++;
        if (out_valid !== 1'b0) $display("FAIL latency_early: got valid=%0b, required 0", out_valid);
        else n_pass++;
        repeat (2) begin
            @(negedge clk);
            n_checks++;
            if ({out_valid, out_r, out_i} !== {1'b1, er, ei})
                $display("FAIL round_head: got valid=%0b r=%0d i=%0d, required valid=1 r=%0d i=%0d",
                         out_valid, $signed(out_r), $signed(out_i), $signed(er), $signed(ei));
            else
                n_pass++;
        end
        @(posedge clk);
        #1 out_ready = 1'b1;
        @(posedge clk);
        #1 out_ready = 1'b0;
    endtask

    task automatic test_rounding();
        apply_reset();
        round_case(26'd1535, 26'd1536, 16'd1, 16'd2);
        round_case(-26'sd1536, 26'h2000000, 16'hFFFF, 16'h8000);
        n_checks++;
        if (sat_seen !== 1'b0) $display("FAIL sat_none: got sat_seen=%0b, required 0", sat_seen);
        else n_pass++;
        round_case(26'h1FFFFFF, 26'd0, 16'h7FFF, 16'h0000);
        n_checks++;
        if (sat_seen !== 1'b1) $display("FAIL sat_set: got sat_seen=%0b, required 1", sat_seen);
        else n_pass++;
        wait_drain(20);
    endtask

    task automatic test_clr_sat();
        clr_flags = 1'b1;
        @(posedge clk);
        #1 clr_flags = 1'b0;
        @(negedge clk);
        n_checks++;
        if (sat_seen !== 1'b0) $display("FAIL sat_clear: got sat_seen=%0b, required 0", sat_seen);
        else n_pass++;
        out_ready = 1'b1;
        clr_flags = 1'b1;
        drive_sample(26'h1FFFFFF, 26'd0, 1'b1);
        clr_flags = 1'b0;
        in_valid  = 1'b0;
        @(negedge clk);
        n_checks++;
        if (sat_seen !== 1'b1) $display("FAIL sat_clr_coincident: got sat_seen=%0b, required 1", sat_seen);
        else n_pass++;
        wait_drain(20);
    endtask

    task automatic test_full_slot();
        apply_reset();
        out_ready = 1'b1;
        for (int k = 0; k <= SLOT_LEN; k++) drive_sample(26'($urandom), 26'($urandom), 1'b1);
        in_valid = 1'b0;
        wait_drain(100);
        n_checks++;
        if ({beats, eos_beats, sos_beats} !== {SLOT_LEN + 1, 32'd14, 32'd2})
            $display("FAIL slot_markers: got beats=%0d eos=%0d sos=%0d, required beats=%0d eos=14 sos=2",
                     beats, eos_beats, sos_beats, SLOT_LEN + 1);
        else
            n_pass++;
    endtask

    task automatic test_overflow();
        apply_reset();
        out_ready = 1'b0;
        for (int k = 0; k < DEPTH + 3; k++) begin
            drive_sample(26'(k * 1000 - 250000), 26'(k * 37), k < DEPTH);
            if (k == DEPTH) begin
                n_checks++;
                if ({overflow, fill} !== {1'b0, 10'd512})
                    $display("FAIL ovf_before_drop: got ovf=%0b fill=%0d, required ovf=0 fill=512", overflow, fill);
                else
                    n_pass++;
            end
        end
        in_valid = 1'b0;
        @(posedge clk);
        #1;
        n_checks++;
        if ({overflow, fill} !== {1'b1, 10'd512})
            $display("FAIL ovf_set: got ovf=%0b fill=%0d, required ovf=1 fill=512", overflow, fill);
        else
            n_pass++;
        clr_flags = 1'b1;
        @(posedge clk);
        #1 clr_flags = 1'b0;
        n_checks++;
        if ({overflow, fill} !== {1'b0, 10'd512})
            $display("FAIL ovf_clear: got ovf=%0b fill=%0d, required ovf=0 fill=512", overflow, fill);
        else
            n_pass++;
    endtask

    // Continues from a full FIFO: every cycle both writes and reads.
    task automatic test_full_rw();
        beats = 0;
        drive_sample(26'd777 * 26'd1024, -26'sd5000, 1'b1);
        out_ready = 1'b1;
        for (int n = 0; n < 21; n++) begin
            n_checks++;
            if ({overflow, fill} !== {1'b0, 10'd512})
                $display("FAIL full_rw_%0d: got ovf=%0b fill=%0d, required ovf=0 fill=512", n, overflow, fill);
            else
                n_pass++;
            if (n < 20) drive_sample(26'(n * 4096 + 100), 26'(-n * 2048), 1'b1);
        end
        in_valid = 1'b0;
        @(posedge clk);
        #1;
        n_checks++;
        if (fill !== 10'd512) $display("FAIL full_rw_tail: got fill=%0d, required 512", fill);
        else n_pass++;
        wait_drain(700);
        n_checks++;
        if ({beats, 31'd0, overflow} !== {32'd533, 32'd0})
            $display("FAIL full_rw_drain: got beats=%0d ovf=%0b, required beats=533 ovf=0", beats, overflow);
        else
            n_pass++;
    endtask

    task automatic test_reset_mid();
        apply_reset();
        out_ready = 1'b1;
        for (int k = 0; k < 1000; k++) drive_sample(26'(k * 513), 26'(k * 129), 1'b1);
        apply_reset();
        for (int k = 0; k < 5; k++) drive_sample(26'(k * 2048 + 1), 26'(k), 1'b1);
        in_valid = 1'b0;
        wait_drain(20);
        n_checks++;
        if ({first_sos, beats} !== {1'b1, 32'd5})
            $display("FAIL reset_mid_sos: got sos=%0b beats=%0d, required sos=1 beats=5", first_sos, beats);
        else
            n_pass++;
    endtask

    initial begin : watchdog
        #3000000;
        $display("FAIL watchdog: simulation still running, required completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int e = 0;
        for (int s = 0; s < 14; s++) begin
            e += (s == 0 || s == 7) ? 2208 : 2192;
            sym_end[s] = e;
        end
        test_reset();
        test_rounding();
        test_clr_sat();
        test_full_slot();
        test_overflow();
        test_full_rw();
        test_reset_mid();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/tx_sample_framer.md
# tx_sample_framer

Output stage downstream of the PUSCH transmit chain. Consumes the time-domain IFFT+CP sample stream (`Data_r`, `Data_i`, `Data_valid`) and tracks sample, symbol and slot position against the NR CP pattern. Rounds and saturates each sample to the DAC/fronthaul width, buffers the samples in a first-word-fall-through FIFO, and presents them on a valid/ready stream with symbol and slot markers. Upstream has no backpressure, so overflow is detected and flagged, never stalled.

## Interface
- `WIDTH_IN`, 26, input sample width per component (signed)
- `WIDTH_OUT`, 16, output sample width per component (signed)
- `SHIFT`, 10, right-shift applied before saturation
- `FFT_LEN`, 2048, useful samples per symbol
- `CP_NORM`, 144, normal CP length in samples
- `CP_LONG`, 160, long CP length in samples
- `SYMS_PER_SLOT`, 14, symbols per slot
- `LONG_CP_MASK`, 14'b00000010000001, bit n set means symbol n uses `CP_LONG`
- `FIFO_DEPTH`, 512, buffer depth (power of two)

Ports:
- `clk` in 1: single clock.
- `rst_n` in 1: asynchronous, active-low reset.
- `in_r`, `in_i` in `WIDTH_IN`: signed sample from the IFFT/CP stage.
- `in_valid` in 1: sample qualifier, one sample per asserted cycle.
- `clr_flags` in 1: synchronous pulse that clears the sticky flags.
- `out_r`, `out_i` out `WIDTH_OUT`: rounded, saturated sample.
- `out_valid` out 1: FIFO non-empty.
- `out_ready` in 1: sink accepts; a beat transfers when valid and ready are both high.
- `out_sos` out 1: first sample of a slot, i.e. symbol 0, CP sample 0.
- `out_eos` out 1: last sample of a symbol.
- `overflow` out 1: sticky; a sample was dropped because the FIFO was full.
- `sat_seen` out 1: sticky; at least one component saturated.
- `fill` out clog2(`FIFO_DEPTH`)+1: current FIFO occupancy.

## Operation
- Per component, in stage 1:
  - compute `y = (x + 2^(SHIFT-1)) >>> SHIFT` with arithmetic shift (round half up), at `WIDTH_IN+1` bits.
  - clamp `y` to [-2^(WIDTH_OUT-1), 2^(WIDTH_OUT-1)-1]; if either component clamps, set `sat_seen`.
- Position counters advance on each `in_valid`, whether or not the sample is stored:
  - `samp_cnt` runs 0 .. `cp_len+FFT_LEN-1`, where `cp_len` is `CP_LONG` if `LONG_CP_MASK[sym_cnt]` is set, else `CP_NORM`.
  - `sym_cnt` runs 0 .. `SYMS_PER_SLOT-1`.
  - At the last sample: `eos=1`, `samp_cnt` goes to 0, `sym_cnt` increments, wrapping to 0 after 13.
  - `sos=1` when `sym_cnt==0` and `samp_cnt==0`.
- FIFO word is {r, i, sos, eos}, written when stage 1 holds a valid sample.
  - If the FIFO is full on a write, drop the word and set `overflow`. Markers of dropped words are lost; counters are not affected.
- Simultaneous write and read when full: the read frees a slot, the write succeeds, no overflow.
- Simultaneous write and read when empty: the write is stored, `out_valid` rises next cycle.
- `clr_flags` in the same cycle as a new overflow or saturation event: the set wins.
- `rst_n` low at any time:
  - empties the FIFO
  - zeroes the counters and stage 1
  - clears the flags
  - the next `in_valid` after reset is treated as slot start

## Timing
- Reset values: `out_r=out_i=0`, `out_valid=0`, `out_sos=out_eos=0`, `overflow=0`, `sat_seen=0`, `fill=0`.
- Latency: sample at edge k is registered in stage 1 at k, written to the FIFO at k+1, and `out_valid` is high after edge k+1 (2 cycles, FIFO empty).
- Data and markers on `out_*` stay stable while `out_valid && !out_ready`.
- `fill` updates the cycle after a write/read; sticky flags rise the cycle after the event.
- Sustained throughput: 1 sample/cycle in and out.

## Structure
- Shared package `pusch_pkg` holds:
  - the NR numerology constants (`FFT_LEN`, `CP_NORM`, `CP_LONG`, `SYMS_PER_SLOT`, `LONG_CP_MASK`)
  - a `round_sat` function, parameterised by widths and shift
- Sub-module `sync_fifo_fwft` (parameters: width, depth), instantiated once.
- Top of the block: stage-1 rounding, position counters, flag logic.

## Test plan
- Rounding, `SHIFT=10`:
  - input 1535 -> 1; 1536 -> 2
  - input -1536 -> -1
  - input 2^25-1 -> 32767 with `sat_seen=1`
  - input -2^25 -> -32768
- One full slot of continuous `in_valid` with `out_ready=1` (30 720 samples):
  - `out_sos` on beat 0
  - `out_eos` on beats 2207, 4399, … (symbols 0 and 7 are 2208 long, others 2192)
  - last `out_eos` on beat 30 719; next beat has `out_sos`
- `out_ready=0` for `FIFO_DEPTH+3` valid inputs: `fill=512`, `overflow=1`, 3 samples dropped. After releasing ready, the first 512 samples drain in order.
- Full FIFO with simultaneous read and write: no overflow, `fill` stays at 512.
- Assert `rst_n` low mid-symbol (`samp_cnt=1000`), release, restart input: `out_valid=0` during reset; the first new output has `out_sos=1`.
- `clr_flags` pulse after overflow clears `overflow`; `clr_flags` coincident with a new saturation leaves `sat_seen=1`.
